// File: rtl/alu_pkg.sv
// Shared definitions for the 32-bit ALU: operation codes, width and a 1-bit
// full-adder helper used to build the shared adder/subtractor.
package alu_pkg;

   localparam int ALU_W = 32;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_XOR = 3'b001,
      ALU_SUB = 3'b010,
      ALU_RSV = 3'b011,
      ALU_SLT = 3'b100,
      ALU_NOR = 3'b101,
      ALU_AND = 3'b110,
      ALU_OR  = 3'b111
   } alu_op_t;

   // One-bit full adder; returns {carry_out, sum}.
   function automatic logic [1:0] full_add(input logic a, input logic b, input logic cin);
      logic s;
      logic co;
      s  = a ^ b ^ cin;
      co = (a & b) | (a & cin) | (b & cin);
      return {co, s};
   endfunction

endpackage

// File: rtl/alu_addsub32.sv
// Shared 32-bit ripple-carry adder/subtractor built from 1-bit full adders.
// With sub=1 operand B is inverted and the carry-in is set, giving A + ~B + 1.
module alu_addsub32
   import alu_pkg::*;
(
   input  logic [ALU_W-1:0] a,
   input  logic [ALU_W-1:0] b,
   input  logic             sub,
   output logic [ALU_W-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   logic [ALU_W-1:0] b_eff_s;
   logic [ALU_W:0]   carry_s;

   // Conditionally invert B for subtraction.
   assign b_eff_s = b ^ {ALU_W{sub}};

   // Ripple the carry through the full-adder chain, LSB first.
   always_comb begin
      logic [1:0] fa_s;
      sum        = {ALU_W{1'b0}};
      carry_s    = {(ALU_W+1){1'b0}};
      fa_s       = 2'b00;
      carry_s[0] = sub;
      for (int i = 0; i < ALU_W; i++) begin
         fa_s           = full_add(a[i], b_eff_s[i], carry_s[i]);
         sum[i]         = fa_s[0];
         carry_s[i + 1] = fa_s[1];
      end
   end

   // Carry-out and signed overflow (carry into MSB differs from carry out of MSB).
   assign cout = carry_s[ALU_W];
   assign ovf  = carry_s[ALU_W] ^ carry_s[ALU_W-1];

endmodule

// File: rtl/alu_32bit.sv
// 32-bit MIPS-style ALU for the execute stage. A combinational result mux
// over the logic units and the shared adder feeds a single output register,
// so each result appears one clock after its operands and select.
module alu_32bit
   import alu_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   output logic [ALU_W-1:0] out,
   input  logic [ALU_W-1:0] inp_A,
   input  logic [ALU_W-1:0] inp_B,
   input  logic [2:0]       select
);

   alu_op_t          op_s;
   logic             sub_s;
   logic [ALU_W-1:0] sum_s;
   logic             addsub_cout_unused;
   logic             ovf_s;
   logic             slt_s;
   logic [ALU_W-1:0] out_d;
   logic [ALU_W-1:0] out_q;

   assign op_s = alu_op_t'(select);

   // Subtract mode is needed both for SUB and for the SLT comparison.
   always_comb begin
      sub_s = 1'b0;
      case (op_s)
         ALU_SUB: sub_s = 1'b1;
         ALU_SLT: sub_s = 1'b1;
         default: sub_s = 1'b0;
      endcase
   end

   alu_addsub32 u_addsub (
      .a    (inp_A),
      .b    (inp_B),
      .sub  (sub_s),
      .sum  (sum_s),
      .cout (addsub_cout_unused),
      .ovf  (ovf_s)
   );

   // Signed less-than stays correct when A-B overflows.
   assign slt_s = sum_s[ALU_W-1] ^ ovf_s;

   // Result mux selecting the operation output for the register input.
   always_comb begin
      out_d = {ALU_W{1'b0}};
      case (op_s)
         ALU_ADD: out_d = sum_s;
         ALU_XOR: out_d = inp_A ^ inp_B;
         ALU_SUB: out_d = sum_s;
         ALU_RSV: out_d = {ALU_W{1'b0}};
         ALU_SLT: out_d = {{(ALU_W-1){1'b0}}, slt_s};
         ALU_NOR: out_d = ~(inp_A | inp_B);
         ALU_AND: out_d = inp_A & inp_B;
         ALU_OR:  out_d = inp_A | inp_B;
         default: out_d = {ALU_W{1'b0}};
      endcase
   end

   // Output register; reset clears it immediately and holds it at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q <= {ALU_W{1'b0}};
      end else begin
         out_q <= out_d;
      end
   end

   assign out = out_q;

endmodule

// File: tb/tb_alu_32bit.sv
// Self-checking bench for alu_32bit: table of directed vectors with
// hand-computed results, asynchronous reset sequence, and a back-to-back
// random run checked against a behavioural reference.
module tb_alu_32bit;

   typedef struct {
      logic [2:0]  sel;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic [31:0] out;
   logic [31:0] inp_A;
   logic [31:0] inp_B;
   logic [2:0]  select;

   int n_tests;
   int n_fail;
   vec_t vecs[$];

   alu_32bit dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .out    (out),
      .inp_A  (inp_A),
      .inp_B  (inp_B),
      .select (select)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] ref_alu(input logic [2:0] s, input logic [31:0] a,
                                           input logic [31:0] b);
      case (s)
         3'b000:  return a + b;
         3'b001:  return a ^ b;
         3'b010:  return a - b;
         3'b100:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'b101:  return ~(a | b);
         3'b110:  return a & b;
         3'b111:  return a | b;
         default: return 32'd0;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic add_vec(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] e);
      vec_t v;
      v.sel = s; v.a = a; v.b = b; v.exp = e;
      vecs.push_back(v);
   endtask

   initial begin
      logic [31:0] pa[4];
      logic [31:0] pb[4];
      logic [31:0] e_add[4], e_sub[4], e_xor[4], e_nor[4], e_and[4], e_or[4], e_slt[4];
      logic [2:0]  cur_sel;
      logic [31:0] cur_a, cur_b, exp_v;

      n_tests = 0;
      n_fail  = 0;

      pa = '{32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      pb = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF};
      e_add = '{32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
      e_sub = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000};
      e_xor = '{32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
      e_nor = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
      e_and = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF};
      e_or  = '{32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      e_slt = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0001, 32'h0000_0000};

      for (int i = 0; i < 4; i++) begin
         add_vec(3'b000, pa[i], pb[i], e_add[i]);
         add_vec(3'b010, pa[i], pb[i], e_sub[i]);
         add_vec(3'b001, pa[i], pb[i], e_xor[i]);
         add_vec(3'b101, pa[i], pb[i], e_nor[i]);
         add_vec(3'b110, pa[i], pb[i], e_and[i]);
         add_vec(3'b111, pa[i], pb[i], e_or[i]);
         add_vec(3'b100, pa[i], pb[i], e_slt[i]);
      end
      add_vec(3'b100, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001);
      add_vec(3'b100, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000);
      add_vec(3'b100, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000);
      add_vec(3'b011, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_0000);
      add_vec(3'b000, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789);
      add_vec(3'b010, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE);

      // Initial reset
      rst_n  = 1'b0;
      inp_A  = 32'd0;
      inp_B  = 32'd0;
      select = 3'b000;
      #12;
      check("reset_initial", out, 32'h0000_0000);
      @(negedge clk);
      rst_n = 1'b1;

      // Table-driven vectors, one cycle latency each
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         select = vecs[i].sel;
         inp_A  = vecs[i].a;
         inp_B  = vecs[i].b;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_sel%03b", i, vecs[i].sel), out, vecs[i].exp);
      end

      // Mid-stream asynchronous reset with nonzero out
      @(negedge clk);
      select = 3'b111;
      inp_A  = 32'hA5A5_0000;
      inp_B  = 32'h0000_5A5A;
      @(posedge clk);
      #1;
      check("pre_reset_nonzero", out, 32'hA5A5_5A5A);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_clears", out, 32'h0000_0000);
      @(posedge clk);
      #1;
      check("reset_holds_zero", out, 32'h0000_0000);
      @(negedge clk);
      rst_n  = 1'b1;
      select = 3'b000;
      inp_A  = 32'h0000_0001;
      inp_B  = 32'h0000_0002;
      @(posedge clk);
      #1;
      check("first_after_reset", out, 32'h0000_0003);

      // Back-to-back random operations, new inputs every cycle
      cur_sel = 3'($urandom_range(0, 7));
      cur_a   = $urandom;
      cur_b   = $urandom;
      select  = cur_sel;
      inp_A   = cur_a;
      inp_B   = cur_b;
      for (int i = 0; i < 16; i++) begin
         @(posedge clk);
         #1;
         exp_v   = ref_alu(cur_sel, cur_a, cur_b);
         cur_sel = 3'($urandom_range(0, 7));
         cur_a   = $urandom;
         cur_b   = $urandom;
         select  = cur_sel;
         inp_A   = cur_a;
         inp_B   = cur_b;
         check($sformatf("b2b%0d", i), out, exp_v);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
